prga_decrypt: RTL and testbench
===============================

Name: prga_decrypt

Overview:
- Third RC4 stage; runs after the key-scheduling shuffle stage has permuted the 256-byte S memory.
- Generates the keystream (PRGA), XORs it with the encrypted message ROM and writes the plaintext to the decrypted-message RAM.
- Shares the single-port S memory with the earlier stages. Uses the same start/finished handshake as the shuffle stage.

Parameters:
- MSG_LEN, 32, number of message bytes to decrypt (1..2^MSG_AW).
- MSG_AW, 5, address width of the message ROM and RAM.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- finished  out  1  one-cycle pulse at end of run.
- address_out  out  8  S memory address.
- data  out  8  S memory write data.
- write_en  out  1  S memory write enable.
- read_data  in  8  S memory read data, valid the cycle after address_out is presented.
- rom_addr  out  MSG_AW  encrypted ROM address.
- rom_data  in  8  encrypted byte, same 1-cycle latency as read_data.
- ram_addr  out  MSG_AW  decrypted RAM address.
- ram_data  out  8  decrypted byte.
- ram_wren  out  1  decrypted RAM write enable.
- key_bad  out  1  invalid-plaintext flag (see Optional Feature).

Behaviour:
- Reset (async): state goes to IDLE; i, j, k, si, sj, f, enc are cleared to 0. All outputs read 0 while reset_n is low.
- Moore FSM; outputs decode from the state register and internal registers only.
- Reset asserted mid-run aborts the run immediately; nothing further is written.
- Arithmetic is 8-bit, wrapping modulo 256: i, j and the f address si+sj.
- k is MSG_AW bits wide.
- States and transitions:
  - IDLE: on start=1, set i←1, j←0, k←0 and go to RD_SI.
  - RD_SI: address_out=i.
  - LT_SI: si←read_data; j←j+read_data.
  - RD_SJ: address_out=j (the updated j).
  - LT_SJ: sj←read_data.
  - WR_SI: address_out=i, data=sj, write_en=1.
  - WR_SJ: address_out=j, data=si, write_en=1.
  - RD_F: address_out=si+sj; rom_addr=k.
  - LT_F: f←read_data; enc←rom_data.
  - WR_OUT: ram_addr=k, ram_data=f^enc, ram_wren=1.
    - If k==MSG_LEN-1, go to DONE.
    - Otherwise k←k+1, i←i+1, go to RD_SI.
  - DONE: finished=1 for exactly one cycle, then IDLE.
- Timing: 9 cycles per byte.
  - The first ram_wren is high 9 cycles after the start-sampling edge.
  - finished is high 9*MSG_LEN+1 cycles after that edge.
- In every state except WR_SI/WR_SJ, write_en=0 and data=0.
- In every state except WR_OUT, ram_wren=0.
- Case i==j: both swap writes hit the same address with unchanged values; the f read follows the writes, so there is no hazard.
- start is ignored outside IDLE. start held high through DONE begins a new run at the IDLE sample after DONE, with i=1, j=0, k=0 and S left as is.
- Address outputs in non-accessing states are don't-care. The bench checks addresses only in the states listed above.

Optional Feature:
- Macro: PRGA_VALID_CHECK_EN.
- Defined: in WR_OUT, if f^enc is not in 0x61..0x7A and not 0x20:
  - ram_wren stays 0;
  - key_bad←1;
  - next state is DONE, so finished pulses the following cycle.
- key_bad holds until the next start sampled in IDLE, or reset.
- Undefined: key_bad is tied 0 and every byte is written.

Test Plan:
- Identity S (s[x]=x), enc[0]=0x63, enc[1]=0x75, MSG_LEN=2, one start pulse:
  - byte 0: address_out=1,1 reads; writes s[1]=1 twice; f read at 0x02; ram_data=0x61 at ram_addr 0, 9 cycles after start.
  - byte 1: j=3, swap s[2]=3 and s[3]=2, f address 0x05, ram_data=0x70.
  - finished 19 cycles after start.
- All-0xFF S, MSG_LEN=2: byte 0 RD_SJ address 0xFF; byte 1 RD_SJ address 0xFE (wrap); RD_F address 0xFE both bytes.
- start pulsed again during LT_SJ of byte 0 -> no effect; exactly MSG_LEN ram_wren pulses and one finished.
- reset_n low during WR_SI of byte 1 -> all outputs 0 at once. After release: no writes until start, then a clean run from i=1, j=0, k=0.
- With PRGA_VALID_CHECK_EN, identity S, enc[0]=0x63, enc[1]=0x00 (plaintext 0x05):
  - one ram_wren only (byte 0);
  - key_bad=1 and finished pulse 10 cycles after the byte-0 write;
  - key_bad clears at the next start.
- Without PRGA_VALID_CHECK_EN, same stimulus -> both bytes written (0x61, 0x05), key_bad=0.

Source files
------------

// File: rtl/prga_decrypt.sv
// RC4 keystream stage: walks i/j over the shared S memory, swaps, XORs the keystream with the ROM bytes and writes the plaintext to RAM.
// Optional PRGA_VALID_CHECK_EN: abort and raise key_bad on the first plaintext byte outside a-z / space.
module prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              finished,
    output logic [7:0]        address_out,
    output logic [7:0]        data,
    output logic              write_en,
    input  logic [7:0]        read_data,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [MSG_AW-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              key_bad
);

    typedef enum logic [3:0] {
        IDLE, RD_SI, LT_SI, RD_SJ, LT_SJ, WR_SI, WR_SJ, RD_F, LT_F, WR_OUT, DONE
    } state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_i, r_j, r_si, r_sj, r_f, r_enc;
    logic [MSG_AW-1:0] r_k;
    logic [7:0]        w_plain;
    logic              w_last;
    logic              w_ok;

    assign w_plain = r_f ^ r_enc;
    assign w_last  = (r_k == MSG_AW'(MSG_LEN - 1));

`ifdef PRGA_VALID_CHECK_EN
    logic r_key_bad;
    assign w_ok    = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);
    assign key_bad = r_key_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         r_key_bad <= 1'b0;
        else if (r_state == IDLE && start)    r_key_bad <= 1'b0;
        else if (r_state == WR_OUT && !w_ok)  r_key_bad <= 1'b1;
    end
`else
    assign w_ok    = 1'b1;
    assign key_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Datapath registers; the S-memory read lands one cycle after its address state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_k   <= '0;
            r_si  <= 8'd0;
            r_sj  <= 8'd0;
            r_f   <= 8'd0;
            r_enc <= 8'd0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_i <= 8'd1;
                    r_j <= 8'd0;
                    r_k <= '0;
                end
                LT_SI: begin
                    r_si <= read_data;
                    r_j  <= r_j + read_data;
                end
                LT_SJ: r_sj <= read_data;
                LT_F: begin
                    r_f   <= read_data;
                    r_enc <= rom_data;
                end
                WR_OUT: if (!w_last && w_ok) begin
                    r_k <= r_k + 1'b1;
                    r_i <= r_i + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        address_out = 8'd0;
        data        = 8'd0;
        write_en    = 1'b0;
        rom_addr    = '0;
        ram_addr    = '0;
        ram_data    = 8'd0;
        ram_wren    = 1'b0;
        finished    = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = RD_SI;
            RD_SI: begin address_out = r_i; w_next = LT_SI; end
            LT_SI: w_next = RD_SJ;
            RD_SJ: begin address_out = r_j; w_next = LT_SJ; end
            LT_SJ: w_next = WR_SI;
            WR_SI: begin
                address_out = r_i;
                data        = r_sj;
                write_en    = 1'b1;
                w_next      = WR_SJ;
            end
            WR_SJ: begin
                address_out = r_j;
                data        = r_si;
                write_en    = 1'b1;
                w_next      = RD_F;
            end
            RD_F: begin
                address_out = r_si + r_sj;
                rom_addr    = r_k;
                w_next      = LT_F;
            end
            LT_F: w_next = WR_OUT;
            WR_OUT: begin
                ram_addr = r_k;
                ram_data = w_plain;
                ram_wren = w_ok;
                w_next   = (w_last || !w_ok) ? DONE : RD_SI;
            end
            DONE: begin finished = 1'b1; w_next = IDLE; end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed bench for prga_decrypt with MSG_LEN=2: bench-owned S memory and ROM, per-cycle capture after each start.
module tb_prga_decrypt;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       finished;
    logic [7:0] address_out, data, read_data, ram_data, rom_data;
    logic       write_en, ram_wren, key_bad;
    logic [4:0] rom_addr, ram_addr;

    logic [7:0] smem [0:255];
    logic [7:0] rom  [0:31];
    logic [1:0] s_init = 2'd0;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr, n_fin;

    logic [7:0] a_addr  [0:63];
    logic [7:0] a_data  [0:63];
    logic       a_we    [0:63];
    logic [4:0] a_rom   [0:63];
    logic       a_rwr   [0:63];
    logic [4:0] a_raddr [0:63];
    logic [7:0] a_rdata [0:63];
    logic       a_fin   [0:63];
    logic       a_kb    [0:63];

    prga_decrypt #(.MSG_LEN(2), .MSG_AW(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .finished(finished),
        .address_out(address_out), .data(data), .write_en(write_en),
        .read_data(read_data), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
        .key_bad(key_bad)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_init == 2'd1)      for (int x = 0; x < 256; x++) smem[x] <= 8'(x);
        else if (s_init == 2'd2) for (int x = 0; x < 256; x++) smem[x] <= 8'hFF;
        else if (write_en)       smem[address_out] <= data;
        read_data <= smem[address_out];
        rom_data  <= rom[rom_addr];
    end

    task automatic load_s(input logic [1:0] mode);
        @(negedge clk); s_init = mode;
        @(negedge clk); s_init = 2'd0;
    endtask

    // Pulse start, then record outputs at the falling edge of cycles 1..ncyc; xs re-asserts start in cycle xs.
    task automatic run_cap(input int ncyc, input int xs);
        n_wr = 0; n_fin = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            a_addr[c] = address_out; a_data[c] = data; a_we[c] = write_en;
            a_rom[c] = rom_addr; a_rwr[c] = ram_wren; a_raddr[c] = ram_addr;
            a_rdata[c] = ram_data; a_fin[c] = finished; a_kb[c] = key_bad;
            if (ram_wren) n_wr++;
            if (finished) n_fin++;
            start = (c == xs);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({finished, address_out, data, write_en, rom_addr, ram_addr, ram_data, ram_wren, key_bad} !== '0) begin
            n_err++; $display("FAIL reset_outputs got %0h required 0",
                {finished, address_out, data, write_en, rom_addr, ram_addr, ram_data, ram_wren, key_bad});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({write_en, ram_wren, finished} !== 3'b000) begin
            n_err++; $display("FAIL idle_quiet got %b required 000", {write_en, ram_wren, finished});
        end
    endtask

    task automatic test_identity();
        int cyc [9]  = '{1, 3, 5, 6, 7, 12, 14, 15, 16};
        logic [7:0] ea [9] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h02, 8'h03, 8'h05};
        rom[0] = 8'h63; rom[1] = 8'h75;
        load_s(2'd1);
        run_cap(22, -1);
        for (int n = 0; n < 9; n++) begin
            n_cmp++;
            if (a_addr[cyc[n]] !== ea[n]) begin
                n_err++; $display("FAIL id_addr_c%0d got %0h required %0h", cyc[n], a_addr[cyc[n]], ea[n]);
            end
        end
        n_cmp++;
        if ({a_we[5], a_data[5], a_we[6], a_data[6]} !== {1'b1, 8'h01, 1'b1, 8'h01}) begin
            n_err++; $display("FAIL id_swap0 got %0h required %0h", {a_we[5], a_data[5], a_we[6], a_data[6]}, {1'b1, 8'h01, 1'b1, 8'h01});
        end
        n_cmp++;
        if ({a_we[14], a_data[14], a_we[15], a_data[15]} !== {1'b1, 8'h03, 1'b1, 8'h02}) begin
            n_err++; $display("FAIL id_swap1 got %0h required %0h", {a_we[14], a_data[14], a_we[15], a_data[15]}, {1'b1, 8'h03, 1'b1, 8'h02});
        end
        n_cmp++;
        if ({a_we[7], a_data[7], a_rom[7], a_rom[16]} !== {1'b0, 8'h00, 5'd0, 5'd1}) begin
            n_err++; $display("FAIL id_rdf got %0h required %0h", {a_we[7], a_data[7], a_rom[7], a_rom[16]}, {1'b0, 8'h00, 5'd0, 5'd1});
        end
        n_cmp++;
        if ({a_rwr[8], a_rwr[9], a_raddr[9], a_rdata[9]} !== {1'b0, 1'b1, 5'd0, 8'h61}) begin
            n_err++; $display("FAIL id_byte0 got %0h required %0h", {a_rwr[8], a_rwr[9], a_raddr[9], a_rdata[9]}, {1'b0, 1'b1, 5'd0, 8'h61});
        end
        n_cmp++;
        if ({a_rwr[18], a_raddr[18], a_rdata[18]} !== {1'b1, 5'd1, 8'h70}) begin
            n_err++; $display("FAIL id_byte1 got %0h required %0h", {a_rwr[18], a_raddr[18], a_rdata[18]}, {1'b1, 5'd1, 8'h70});
        end
        n_cmp++;
        if ({a_fin[18], a_fin[19], a_fin[20]} !== 3'b010) begin
            n_err++; $display("FAIL id_finished got %b required 010", {a_fin[18], a_fin[19], a_fin[20]});
        end
        n_cmp++;
        if ({smem[1], smem[2], smem[3]} !== {8'h01, 8'h03, 8'h02}) begin
            n_err++; $display("FAIL id_smem got %0h required 010302", {smem[1], smem[2], smem[3]});
        end
    endtask

    task automatic test_wrap();
        rom[0] = 8'h9E; rom[1] = 8'h9E;
        load_s(2'd2);
        run_cap(22, -1);
        n_cmp++;
        if ({a_addr[3], a_addr[12]} !== 16'hFFFE) begin
            n_err++; $display("FAIL wrap_rdsj got %0h required fffe", {a_addr[3], a_addr[12]});
        end
        n_cmp++;
        if ({a_addr[7], a_addr[16]} !== 16'hFEFE) begin
            n_err++; $display("FAIL wrap_rdf got %0h required fefe", {a_addr[7], a_addr[16]});
        end
        n_cmp++;
        if ({a_rdata[9], a_rdata[18], a_fin[19]} !== {8'h61, 8'h61, 1'b1}) begin
            n_err++; $display("FAIL wrap_out got %0h required %0h", {a_rdata[9], a_rdata[18], a_fin[19]}, {8'h61, 8'h61, 1'b1});
        end
    endtask

    task automatic test_start_ignored();
        rom[0] = 8'h63; rom[1] = 8'h75;
        load_s(2'd1);
        run_cap(30, 4);
        n_cmp++;
        if (n_wr !== 2 || n_fin !== 1) begin
            n_err++; $display("FAIL restart_counts got wr=%0d fin=%0d required wr=2 fin=1", n_wr, n_fin);
        end
        n_cmp++;
        if ({a_fin[19], a_rdata[18]} !== {1'b1, 8'h70}) begin
            n_err++; $display("FAIL restart_timing got %0h required 170", {a_fin[19], a_rdata[18]});
        end
    endtask

    task automatic test_midrun_reset();
        int bad = 0;
        rom[0] = 8'h63; rom[1] = 8'h75;
        load_s(2'd1);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if ({write_en, address_out, data} !== {1'b1, 8'h02, 8'h03}) begin
            n_err++; $display("FAIL mr_in_wrsi got %0h required 10203", {write_en, address_out, data});
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({finished, address_out, data, write_en, rom_addr, ram_addr, ram_data, ram_wren, key_bad} !== '0) begin
            n_err++; $display("FAIL mr_outputs got %0h required 0",
                {finished, address_out, data, write_en, rom_addr, ram_addr, ram_data, ram_wren, key_bad});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (write_en || ram_wren || finished) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL mr_quiet got %0d active cycles required 0", bad);
        end
        n_cmp++;
        if (smem[2] !== 8'h02) begin
            n_err++; $display("FAIL mr_no_write got %0h required 02", smem[2]);
        end
        load_s(2'd1);
        run_cap(22, -1);
        n_cmp++;
        if ({a_addr[1], a_addr[3], a_rdata[9], a_rdata[18], a_fin[19]} !== {8'h01, 8'h01, 8'h61, 8'h70, 1'b1}) begin
            n_err++; $display("FAIL mr_clean_run got %0h required %0h",
                {a_addr[1], a_addr[3], a_rdata[9], a_rdata[18], a_fin[19]}, {8'h01, 8'h01, 8'h61, 8'h70, 1'b1});
        end
    endtask

    task automatic test_key_check();
        int kb = 0;
        rom[0] = 8'h63; rom[1] = 8'h00;
        load_s(2'd1);
        run_cap(22, -1);
        n_cmp++;
        if ({a_rwr[9], a_rdata[9]} !== {1'b1, 8'h61}) begin
            n_err++; $display("FAIL kc_byte0 got %0h required 161", {a_rwr[9], a_rdata[9]});
        end
`ifdef PRGA_VALID_CHECK_EN
        n_cmp++;
        if (n_wr !== 1 || a_rwr[18] !== 1'b0) begin
            n_err++; $display("FAIL kc_writes got %0d wr18=%b required 1 wr18=0", n_wr, a_rwr[18]);
        end
        n_cmp++;
        if ({a_fin[19], a_kb[18], a_kb[19], a_kb[22]} !== 4'b1011) begin
            n_err++; $display("FAIL kc_flag got %b required 1011", {a_fin[19], a_kb[18], a_kb[19], a_kb[22]});
        end
        load_s(2'd1);
        rom[1] = 8'h75;
        run_cap(22, -1);
        n_cmp++;
        if ({a_kb[1], a_rdata[18]} !== {1'b0, 8'h70}) begin
            n_err++; $display("FAIL kc_clear got %0h required 070", {a_kb[1], a_rdata[18]});
        end
`else
        for (int c = 1; c <= 22; c++) if (a_kb[c] !== 1'b0) kb++;
        n_cmp++;
        if (n_wr !== 2 || a_rdata[18] !== 8'h05 || a_raddr[18] !== 5'd1) begin
            n_err++; $display("FAIL kc_both_written got wr=%0d data=%0h addr=%0d required 2 05 1", n_wr, a_rdata[18], a_raddr[18]);
        end
        n_cmp++;
        if (kb !== 0 || a_fin[19] !== 1'b1) begin
            n_err++; $display("FAIL kc_no_flag got kb_cycles=%0d fin=%b required 0 1", kb, a_fin[19]);
        end
`endif
    endtask

    initial begin
        for (int x = 0; x < 32; x++) rom[x] = 8'h00;
        test_reset();
        test_identity();
        test_wrap();
        test_start_ignored();
        test_midrun_reset();
        test_key_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
